// File: rtl/prbs_pkg.sv
// Shared definitions for the 10-stage PRBS checker.
// Holds the checker state encoding, the sequence length, the feedback tap
// positions (s[n] = s[n-10] ^ s[n-7]), the loss-of-lock window size, and a
// helper that forms the predicted next bit from the history register.
// History layout used everywhere: hist[k-1] holds s[n-k], so hist[0] is the
// most recent beat and new bits are shifted in at the low end.
package prbs_pkg;

  localparam int PRBS_LEN  = 10;
  localparam int TAP_A     = 10;
  localparam int TAP_B     = 7;
  localparam int WIN_BEATS = 64;
  localparam int WIN_W     = $clog2(WIN_BEATS);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] hist);
    return hist[TAP_A-1] ^ hist[TAP_B-1];
  endfunction

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, forces count to 0
//   clr  - synchronous clear, takes priority over inc
//   inc  - increment request for this cycle
//   cnt  - current count, sticks at all-ones instead of wrapping
module prbs_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over a simultaneous increment; the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker for the s[n] = s[n-10] ^ s[n-7] sequence.
// Hunts for a non-zero 10-bit seed, verifies LOCK_CNT consecutive correct
// predictions, then runs self-synchronised in LOCKED, flagging mismatching
// beats and dropping lock when LOSS_THR errors land in one 64-beat window.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (overrides clr)
//   in_valid - marks a beat; nothing advances when low
//   in_bit   - received serial bit
//   clr      - synchronous clear of err_cnt (and bit_cnt when present)
//   locked   - registered, high while in LOCKED
//   err      - registered one-cycle pulse per mismatching LOCKED beat
//   err_cnt  - saturating count of LOCKED mismatches
//   bit_cnt  - wrapping count of LOCKED beats, only with PRBS_CHECKER_BITCNT_EN
// Optional feature macro: PRBS_CHECKER_BITCNT_EN
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_THR = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHECKER_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int FILL_W  = $clog2(PRBS_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(PRBS_LEN);
  localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(LOCK_CNT);
  localparam logic [WERR_W-1:0]  LOSS_LIM   = WERR_W'(LOSS_THR);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_BEATS - 1);

  prbs_state_e          state_q, state_d;
  logic [PRBS_LEN-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_beat_q, win_beat_d;
  logic [WERR_W-1:0]    win_err_q, win_err_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 err_inc;
  logic                 predict;
  logic                 mismatch;

  assign predict  = prbs_predict(hist_q);
  assign mismatch = in_bit ^ predict;

  // Next-state logic. In LOCKED the prediction rather than the received bit is
  // shifted into the history, so one corrupted bit never poisons later
  // predictions. Window error count reaching the threshold beats the window
  // wrap, so the error on the final beat of a window still counts.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    match_d    = match_q;
    win_beat_d = win_beat_q;
    win_err_d  = win_err_q;
    err_d      = 1'b0;
    err_inc    = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          hist_d = {hist_q[PRBS_LEN-2:0], in_bit};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end
          // An all-zero history is a stuck state of the sequence; keep hunting.
          if ((fill_d == FILL_FULL) && (hist_d != '0)) begin
            state_d = ST_VERIFY;
            match_d = '0;
          end
        end
        ST_VERIFY: begin
          hist_d = {hist_q[PRBS_LEN-2:0], in_bit};
          if (!mismatch) begin
            match_d = match_q + 1'b1;
            if (match_d == MATCH_DONE) begin
              state_d    = ST_LOCKED;
              win_beat_d = '0;
              win_err_d  = '0;
            end
          end else begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end
        end
        ST_LOCKED: begin
          hist_d     = {hist_q[PRBS_LEN-2:0], predict};
          win_beat_d = win_beat_q + 1'b1;
          if (mismatch) begin
            err_d     = 1'b1;
            err_inc   = 1'b1;
            win_err_d = win_err_q + 1'b1;
          end
          if (win_err_d == LOSS_LIM) begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end else if (win_beat_q == WIN_LAST) begin
            win_err_d = '0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      hist_q     <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      win_beat_q <= '0;
      win_err_q  <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      win_beat_q <= win_beat_d;
      win_err_q  <= win_err_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;

  prbs_sat_cnt #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(err_inc),
    .cnt(err_cnt)
  );

`ifdef PRBS_CHECKER_BITCNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;

  // Counts beats spent in LOCKED; wraps freely, clear wins over increment.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      bit_cnt_d = '0;
    end else if (in_valid && (state_q == ST_LOCKED)) begin
      bit_cnt_d = bit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker: directed scenarios plus a randomized soak,
// compared every cycle against a queue-based behavioural model.
module tb_prbs_checker;

  localparam int LOCK_CNT = 16;
  localparam int LOSS_THR = 4;
  localparam int ERR_W    = 4;
  localparam int WIN      = 64;
  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
`ifdef PRBS_CHECKER_BITCNT_EN
  logic [31:0]      bit_cnt;
`endif

  prbs_checker #(
    .LOCK_CNT(LOCK_CNT),
    .LOSS_THR(LOSS_THR),
    .ERR_W(ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .clr(clr),
    .locked(locked),
    .err(err),
    .err_cnt(err_cnt)
`ifdef PRBS_CHECKER_BITCNT_EN
    ,
    .bit_cnt(bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // Behavioural model state: received/predicted history as a queue of bits
  // (index 0 = s[n-10]) and plain integer counters.
  bit          mh[$];
  int          m_mode  = M_HUNT;
  int          m_fill  = 0;
  int          m_match = 0;
  int          m_wbeat = 0;
  int          m_werr  = 0;
  int          m_cnt   = 0;
  int unsigned m_bits  = 0;
  bit          exp_locked = 1'b0;
  bit          exp_err    = 1'b0;

  // Reference generator history (index 0 = oldest).
  bit gh[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every rising edge, using the same sampled inputs as the DUT.
  always @(posedge clk) begin : model
    bit p;
    bit any_one;
    if (rst) begin
      mh.delete();
      for (int i = 0; i < 10; i++) mh.push_back(1'b0);
      m_mode = M_HUNT; m_fill = 0; m_match = 0; m_wbeat = 0; m_werr = 0;
      m_cnt = 0; m_bits = 0; exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      if (in_valid) begin
        p = mh[0] ^ mh[3];
        if (m_mode == M_HUNT) begin
          mh.push_back(in_bit); void'(mh.pop_front());
          if (m_fill < 10) m_fill++;
          any_one = 1'b0;
          foreach (mh[i]) if (mh[i]) any_one = 1'b1;
          if (m_fill == 10 && any_one) begin m_mode = M_VERIFY; m_match = 0; end
        end else if (m_mode == M_VERIFY) begin
          mh.push_back(in_bit); void'(mh.pop_front());
          if (in_bit == p) begin
            m_match++;
            if (m_match == LOCK_CNT) begin m_mode = M_LOCKED; m_wbeat = 0; m_werr = 0; end
          end else begin
            m_mode = M_HUNT; m_fill = 0;
          end
        end else begin
          mh.push_back(p); void'(mh.pop_front());
          m_bits++;
          if (in_bit != p) begin
            exp_err = 1'b1;
            if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
            m_werr++;
          end
          m_wbeat++;
          if (m_werr == LOSS_THR) begin
            m_mode = M_HUNT; m_fill = 0;
          end else if (m_wbeat == WIN) begin
            m_wbeat = 0; m_werr = 0;
          end
        end
      end
      if (clr) begin m_cnt = 0; m_bits = 0; end
    end
    exp_locked = (m_mode == M_LOCKED);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_locked", locked, exp_locked);
      checkOutput("model_err", err, exp_err);
      checkOutput("model_err_cnt", err_cnt, m_cnt);
`ifdef PRBS_CHECKER_BITCNT_EN
      checkOutput("model_bit_cnt", bit_cnt, m_bits);
`endif
    end
  end

  task automatic applyStimulus(input bit v, input bit b, input bit r, input bit c);
    in_valid = v; in_bit = b; rst = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic genReset();
    logic [9:0] seed;
    seed = 10'h001;
    gh.delete();
    for (int i = 0; i < 10; i++) gh.push_back(seed[i]);
  endtask

  task automatic genNext(output bit b);
    b = gh[0] ^ gh[3];
    gh.push_back(b);
    void'(gh.pop_front());
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    genReset();
  endtask

  task automatic sendClean(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin genNext(b); applyStimulus(1'b1, b, 1'b0, 1'b0); end
  endtask

  task automatic sendErr();
    bit b;
    genNext(b);
    applyStimulus(1'b1, ~b, 1'b0, 1'b0);
  endtask

  // Counts valid beats until locked rises; -1 if the bound expires.
  task automatic waitLock(input int pct, output int beats);
    bit b;
    int n;
    beats = -1;
    n = 0;
    for (int i = 0; i < 400 && beats < 0; i++) begin
      if ($urandom_range(99) < pct) begin
        genNext(b);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        n++;
        if (locked === 1'b1) beats = n;
      end else begin
        applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0);
      end
    end
  endtask

  initial begin : main
    int lb;
    bit b, v, r, c, err_seen;

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_err_cnt", err_cnt, 0);

    // Clean stream: lock after 10 fill + 16 verify beats, then no errors.
    genReset();
    waitLock(100, lb);
    checkOutput("lock_beats", lb, 26);
    sendClean(2000 - 26);
    checkOutput("clean_err_cnt", err_cnt, 0);
    checkOutput("clean_locked", locked, 1);

    // Single flipped bit.
    sendErr();
    checkOutput("single_err_pulse", err, 1);
    sendClean(1);
    checkOutput("single_err_next", err, 0);
    sendClean(30);
    checkOutput("single_err_cnt", err_cnt, 1);
    checkOutput("single_locked", locked, 1);

    // Four errors early in a fresh window force loss, then relock in 26 beats.
    doReset();
    waitLock(100, lb);
    sendClean(5);
    sendErr(); sendErr(); sendErr();
    checkOutput("three_err_locked", locked, 1);
    sendErr();
    checkOutput("loss_locked", locked, 0);
    checkOutput("loss_err", err, 1);
    sendClean(25);
    checkOutput("relock_25", locked, 0);
    sendClean(1);
    checkOutput("relock_26", locked, 1);

    // Constant zero input never leaves HUNT.
    doReset();
    err_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      err_seen |= err;
    end
    checkOutput("zeros_locked", locked, 0);
    checkOutput("zeros_err_seen", err_seen, 0);

    // Saturation with a 4-bit counter, then clear coinciding with an error.
    doReset();
    waitLock(100, lb);
    for (int i = 0; i < 20; i++) begin sendClean(29); sendErr(); end
    checkOutput("sat_err_cnt", err_cnt, 15);
    checkOutput("sat_locked", locked, 1);
    genNext(b);
    applyStimulus(1'b1, ~b, 1'b0, 1'b1);
    checkOutput("clr_err_pulse", err, 1);
    checkOutput("clr_wins", err_cnt, 0);

    // Gapped valid gives the same beat count; reset while locked.
    doReset();
    waitLock(50, lb);
    checkOutput("gapped_lock_beats", lb, 26);
    sendErr();
    checkOutput("gapped_err_cnt", err_cnt, 1);
    genNext(b);
    applyStimulus(1'b1, b, 1'b1, 1'b0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);

    // Randomized soak against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(99) < 70);
      r = ($urandom_range(1499) == 0);
      c = ($urandom_range(199) == 0);
      if (v) begin
        genNext(b);
        if ($urandom_range(49) == 0) b = ~b;
      end else begin
        b = 1'($urandom);
      end
      applyStimulus(v, b, r, c);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
